// File: rtl/ram_dump_pkg.sv
// ram_dump_pkg: shared definitions for the RAM dumper and its UART serializer.
//   - FSM state encoding for ram_dumper
//   - UART 8N1 frame constants
// Optional feature macro: RAM_DUMP_CHECKSUM_EN adds the CSUM state.
package ram_dump_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

`ifdef RAM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_ADV  = 3'd4,
    ST_CSUM = 3'd5
  } dump_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_ADV  = 3'd4
  } dump_state_e;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-byte UART 8N1 transmitter.
// Ports:
//   i_clk   - clock, rising edge
//   reset   - asynchronous active-high reset, line returns idle high
//   i_load  - load i_data and start a frame (ignored while busy)
//   i_data  - byte to send, LSB first
//   o_tx    - registered serial line, idle high
//   o_busy  - frame in progress (internal bit timing)
//   o_done  - one-cycle pulse in the final cycle of the internal stop bit
// o_tx lags the internal bit timing by one registered cycle, so o_done
// arrives two cycles before the stop bit finishes on the line. The parent
// uses that lead to fetch the next byte without widening the inter-frame gap.
module uart_tx_byte
  import ram_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_LAST = 4'(FRAME_BITS - 1);

  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        line_bit;

  always_comb begin
    bit_end = busy_q && (cnt_q == CNT_LAST);

    if (idx_q == 4'd0)          line_bit = START_BIT;
    else if (idx_q == IDX_LAST) line_bit = STOP_BIT;
    else                        line_bit = shift_q[0];

    busy_d  = busy_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    if (!busy_q) begin
      if (i_load) begin
        busy_d  = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        shift_d = i_data;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + 4'd1;
        // consume a data bit only once it has been on the line
        if (idx_q != 4'd0) shift_d = {1'b0, shift_q[7:1]};
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    tx_d = busy_q ? line_bit : STOP_BIT;
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = bit_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/ram_dumper.sv
// ram_dumper: on i_start, reads every program RAM location in address order
// and sends each byte over UART 8N1.
// Ports:
//   i_clk        - clock, rising edge
//   reset        - asynchronous active-high reset (abandons any frame)
//   i_start      - one-cycle start request, ignored while busy / in done cycle
//   o_busy       - dump in progress
//   o_done       - one-cycle pulse after the final stop bit
//   o_mem_addr   - RAM read address (held between reads)
//   o_mem_rd     - RAM read strobe, 1-cycle read latency expected
//   i_mem_rdata  - RAM read data
//   o_tx         - serial output, idle high
// Optional feature macro: RAM_DUMP_CHECKSUM_EN appends a two's-complement
// checksum byte so the sum of all sent bytes is 0x00.
module ram_dumper
  import ram_dump_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_tx
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              csum_sent_q, csum_sent_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_load  = 1'b0;
    tx_data  = i_mem_rdata[7:0];
    o_mem_rd = 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
    csum_sent_d = csum_sent_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // a start coinciding with the done pulse belongs to the old dump
        if (i_start && !done_q) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_READ;
`ifdef RAM_DUMP_CHECKSUM_EN
          sum_d       = '0;
          csum_sent_d = 1'b0;
`endif
        end
      end
      ST_READ: begin
        o_mem_rd = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // read data is valid now; the serializer shift register holds it
        tx_load = 1'b1;
        state_d = ST_SEND;
`ifdef RAM_DUMP_CHECKSUM_EN
        sum_d = sum_q + i_mem_rdata[7:0];
`endif
      end
      ST_SEND: begin
        // falling back on !tx_busy keeps a missed load from hanging the FSM
        if (tx_done || !tx_busy) state_d = ST_ADV;
      end
      ST_ADV: begin
        if (addr_q == ADDR_LAST) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          if (!csum_sent_q) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_READ;
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        // first cycle loads the checksum, then wait for its frame; the
        // return to ADV reuses the end-of-dump path with csum_sent set
        if (!csum_sent_q) begin
          tx_load     = 1'b1;
          tx_data     = 8'h00 - sum_q;
          csum_sent_d = 1'b1;
        end else if (tx_done || !tx_busy) begin
          state_d = ST_ADV;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RAM_DUMP_CHECKSUM_EN
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sum_q       <= '0;
      csum_sent_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      csum_sent_q <= csum_sent_d;
    end
  end
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk (i_clk),
    .reset (reset),
    .i_load(tx_load),
    .i_data(tx_data),
    .o_tx  (o_tx),
    .o_busy(tx_busy),
    .o_done(tx_done)
  );

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_mem_addr = addr_q;

endmodule

// File: tb/tb_ram_dumper.sv
module tb_ram_dumper;
  localparam int AW       = 4;
  localparam int CPB      = 4;
  localparam int NWORDS   = 16;
  localparam int BYTE_CYC = 10 * CPB + 3;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam int NB       = NWORDS + 1;
  localparam int DONE_IDX = NWORDS * BYTE_CYC + 10 * CPB + 2;
`else
  localparam int NB       = NWORDS;
  localparam int DONE_IDX = NWORDS * BYTE_CYC;
`endif

  typedef struct {
    logic [7:0]    mem;
    logic [AW-1:0] addr;
    logic [7:0]    exp_byte;
    int            exp_start;
  } vec_t;

  vec_t tbl[NB];

  logic          i_clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_mem_rd, o_tx;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    i_mem_rdata = 8'h00;
  logic [7:0]    ram[NWORDS];

  int n_checks = 0;
  int n_fail   = 0;

  logic          tx_s[$];
  logic          rd_s[$];
  logic          busy_s[$];
  logic          done_s[$];
  logic [AW-1:0] addr_s[$];

  ram_dumper #(.ADDR_W(AW), .DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .i_clk(i_clk), .reset(reset), .i_start(i_start), .o_busy(o_busy),
    .o_done(o_done), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
    .i_mem_rdata(i_mem_rdata), .o_tx(o_tx)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_mem_rd) i_mem_rdata <= ram[o_mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    tx_s.push_back(o_tx);
    rd_s.push_back(o_mem_rd);
    busy_s.push_back(o_busy);
    done_s.push_back(o_done);
    addr_s.push_back(o_mem_addr);
  endtask

  // Sample k is the cycle following the k-th rising edge after the start edge.
  task automatic run_dump(input int start_at, input bit start_on_done,
                          input int rst_at, input int post);
    bit seen_done = 0;
    int left = post;
    bit aborted = 0;
    tx_s.delete(); rd_s.delete(); busy_s.delete(); done_s.delete(); addr_s.delete();
    @(negedge i_clk);
    i_start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      sample();
      i_start = (k == start_at) || (start_on_done && done_s[k] === 1'b1);
      if (k == rst_at) begin
        check("tx_low_before_reset", 32'(tx_s[k]), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_rd", 32'(o_mem_rd), 32'd0);
        @(negedge i_clk);
        check("rst_held_tx", 32'(o_tx), 32'd1);
        reset = 1'b0;
        i_start = 1'b0;
        aborted = 1;
        break;
      end
      if (done_s[k] === 1'b1) seen_done = 1;
      if (seen_done) begin
        if (left == 0) break;
        left--;
      end
    end
    i_start = 1'b0;
    if (!aborted) check("done_within_budget", 32'(seen_done), 32'd1);
  endtask

  task automatic analyze(input string tag);
    int idx = 0, nfr = 0, hold_err = 0, npulse = 0, wide = 0;
    int ndone = 0, first_done = -1, busy_err = 0;
    logic [7:0] b;
    while (idx < tx_s.size()) begin
      if (tx_s[idx] === 1'b0 && idx + 10 * CPB <= tx_s.size()) begin
        for (int bi = 0; bi < 10; bi++)
          for (int c = 0; c < CPB; c++)
            if (tx_s[idx + bi * CPB + c] !== tx_s[idx + bi * CPB]) hold_err++;
        for (int i = 0; i < 8; i++) b[i] = tx_s[idx + (i + 1) * CPB];
        if (nfr < NB) begin
          check($sformatf("%s_byte%0d", tag, nfr), 32'(b), 32'(tbl[nfr].exp_byte));
          check($sformatf("%s_start%0d", tag, nfr), idx, tbl[nfr].exp_start);
          check($sformatf("%s_stop%0d", tag, nfr), 32'(tx_s[idx + 9 * CPB]), 32'd1);
        end
        nfr++;
        idx += 10 * CPB;
      end else begin
        idx++;
      end
    end
    check({tag, "_frames"}, nfr, NB);
    check({tag, "_bit_hold_err"}, hold_err, 0);

    for (int k = 0; k < rd_s.size(); k++) begin
      if (rd_s[k] === 1'b1) begin
        if (npulse < NWORDS)
          check($sformatf("%s_rdaddr%0d", tag, npulse), 32'(addr_s[k]), 32'(tbl[npulse].addr));
        if (k + 1 < rd_s.size() && rd_s[k + 1] === 1'b1) wide++;
        npulse++;
      end
      if (done_s[k] === 1'b1) begin
        if (first_done < 0) first_done = k;
        ndone++;
      end
      if (busy_s[k] !== (k < DONE_IDX)) busy_err++;
    end
    check({tag, "_rd_pulses"}, npulse, NWORDS);
    check({tag, "_rd_wide"}, wide, 0);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_done_idx"}, first_done, DONE_IDX);
    check({tag, "_busy_window_err"}, busy_err, 0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
`ifdef RAM_DUMP_CHECKSUM_EN
      tbl[i].mem = 8'(i);
`else
      tbl[i].mem = 8'(i * 8'h11);
`endif
      tbl[i].addr      = AW'(i);
      tbl[i].exp_byte  = tbl[i].mem;
      tbl[i].exp_start = 3 + i * BYTE_CYC;
      ram[i]           = tbl[i].mem;
    end
`ifdef RAM_DUMP_CHECKSUM_EN
    tbl[NWORDS].mem       = 8'h00;
    tbl[NWORDS].addr      = '0;
    tbl[NWORDS].exp_byte  = 8'h88;
    tbl[NWORDS].exp_start = NWORDS * BYTE_CYC + 2;
`endif

    repeat (3) @(negedge i_clk);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_addr", 32'(o_mem_addr), 32'd0);
    check("reset_rd", 32'(o_mem_rd), 32'd0);
    check("reset_tx", 32'(o_tx), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // basic dump
    run_dump(-1, 1'b0, -1, 20);
    analyze("basic");
    repeat (3) @(negedge i_clk);

    // restart attempts during byte 5 and in the done cycle are ignored
    run_dump(tbl[5].exp_start + 10, 1'b1, -1, 60);
    analyze("busy_start");
    repeat (3) @(negedge i_clk);

    // reset during data bit 3 of byte 7 (a zero bit for both RAM patterns)
    run_dump(-1, 1'b0, tbl[7].exp_start + 4 * CPB + 1, 0);
    repeat (3) @(negedge i_clk);
    check("post_reset_busy", 32'(o_busy), 32'd0);
    check("post_reset_tx", 32'(o_tx), 32'd1);

    // a fresh start after reset dumps from address 0
    run_dump(-1, 1'b0, -1, 10);
    analyze("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dumper.md
Name: ram_dumper

Overview:
Synthesizable read-back path for the 8-bit machine's program RAM: on a start pulse it reads every RAM location in address order and transmits each byte over a UART 8N1 serial line. It is the counterpart of the program loader, used on hardware to verify memory contents over a host serial link. It sits beside machine and uses a dedicated synchronous RAM read port.

Parameters:
ADDR_W, 4, RAM address width; dump length = 2**ADDR_W bytes
DATA_W, 8, RAM word width; fixed at 8 for UART framing
CLKS_PER_BIT, 16, i_clk cycles per UART bit; legal range 2 to 65535

Ports:
i_clk  input  1  system clock; all logic rising-edge
reset  input  1  asynchronous, active-high reset
i_start  input  1  one-cycle start request; ignored while busy
o_busy  output  1  high from the cycle after an accepted start until the last stop bit completes
o_done  output  1  one-cycle pulse after the final stop bit
o_mem_addr  output  ADDR_W  RAM read address
o_mem_rd  output  1  RAM read strobe
i_mem_rdata  input  DATA_W  RAM read data, valid exactly 1 cycle after o_mem_rd
o_tx  output  1  UART serial out; idle high

Behaviour:
- Reset values: o_busy=0, o_done=0, o_mem_addr=0, o_mem_rd=0, o_tx=1, FSM in IDLE, address counter 0. Reset takes effect immediately at any point, including mid-byte: o_tx returns high and the partial frame is abandoned.
- FSM states: IDLE, READ, WAIT, SEND, ADV (plus CSUM when the optional feature is enabled).
- IDLE: when i_start=1, clear the address counter and go to READ.
- READ: o_mem_rd=1 for exactly one cycle with o_mem_addr=counter, then go to WAIT.
- WAIT: capture i_mem_rdata into the TX holding register, pulse tx_load, then go to SEND.
- SEND: wait for tx_done from the serializer, then go to ADV.
- ADV: if counter == 2**ADDR_W-1, go to IDLE (or CSUM), pulse o_done, and drop o_busy. Otherwise increment the counter and go to READ.
- o_mem_addr holds its value between reads. o_mem_rd is 0 outside READ.
- Serializer frame: start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- The first start bit appears on o_tx 3 cycles after i_start is sampled (READ, WAIT, load).
- Inter-byte gap: 3 idle-high cycles (ADV, READ, WAIT) between a stop bit and the next start bit. Total dump time = 2**ADDR_W * (10*CLKS_PER_BIT + 3) cycles, ±1 for the done cycle.
- i_start while o_busy=1 is ignored, with no restart.
- i_start in the same cycle that o_done pulses is ignored. A new start is accepted from the following cycle.
- Counter arithmetic is unsigned ADDR_W bits. The end test is an explicit compare, never wrap detection.

Optional Feature:
Macro RAM_DUMP_CHECKSUM_EN.
- Defined: after the last data byte, ADV goes to CSUM, which transmits one extra byte equal to the 8-bit two's-complement of the modulo-256 sum of all dumped bytes, so the sum of all bytes including the checksum is 0x00. o_done and the o_busy drop occur only after the checksum stop bit. The accumulator clears on start and on reset.
- Not defined: no CSUM state and no accumulator; exactly 2**ADDR_W bytes are sent.

Decomposition:
- Shared package ram_dump_pkg: FSM state encoding enum, UART frame constants (START_BIT=0, STOP_BIT=1, FRAME_BITS=10).
- Sub-module uart_tx_byte, parameter CLKS_PER_BIT. Ports: i_clk, reset, i_load, i_data[7:0], o_tx, o_busy, o_done. It owns the bit-period counter, the bit index counter and the shift register. It is reusable by other serial outputs.

Test Plan:
- Basic dump: ADDR_W=4, CLKS_PER_BIT=4, RAM[i]=i*0x11, one-cycle start -> bench UART receiver decodes 0x00,0x11,...,0xFF in order. o_done pulses once; o_busy falls with it.
- Timing: sample o_tx after start -> first falling edge exactly 3 cycles after the start sample. Each bit is held exactly 4 cycles. Exactly 3 high cycles between consecutive frames.
- Read port protocol: check o_mem_rd pulses -> exactly 16 pulses, one cycle wide, addresses 0..15 each once. i_mem_rdata returned with 1-cycle latency is the byte transmitted.
- Start while busy: re-pulse i_start at byte 5 and again in the o_done cycle -> dump still contains exactly 16 bytes; no second dump starts.
- Reset mid-byte: assert reset during bit 3 of byte 7 -> o_tx=1, o_busy=0 and o_mem_addr=0 immediately (asynchronously). A subsequent start dumps from address 0.
- Checksum (RAM_DUMP_CHECKSUM_EN defined, RAM[i]=i): 16 bytes followed by 0x88 (sum 0x78, negated). o_done only after the 17th stop bit.
